// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file index range over a combinational read port and streams each value out.
// Latency: first beat valid 2 cycles after an accepted dump_start; at most one beat every 2 cycles.
// Backpressure: a beat is held stable until dump_ready; the walk pauses. Define REG_DUMP_CHECKSUM_EN for a trailing XOR beat.
module reg_dump_reader #(
  parameter int  XLEN  = 32,
  parameter int  NREGS = 32,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            dump_start,
  input  logic [IW-1:0]   start_idx,
  input  logic [IW-1:0]   end_idx,
  output logic [IW-1:0]   rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [XLEN-1:0] dump_data,
  output logic [IW-1:0]   dump_idx,
  output logic            dump_last,
  output logic            dump_is_chk,
  output logic            busy,
  output logic            done
);

  // CHK is only reachable when the checksum beat is compiled in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    FIN  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] cur_q;
  logic [IW-1:0] last_q;
  logic          hs;
  logic          at_last;
  logic          empty_req;

  assign hs        = dump_valid && dump_ready;
  assign at_last   = (cur_q == last_q);
  assign empty_req = (start_idx > end_idx);

`ifdef REG_DUMP_CHECKSUM_EN
  // After the register beats (or for an empty range) the checksum beat is built.
  localparam state_t AFTER_REGS = CHK;
  logic [XLEN-1:0] chk_q;
  logic            is_chk_q;
  assign dump_is_chk = is_chk_q;
`else
  localparam state_t AFTER_REGS = FIN;
  assign dump_is_chk = 1'b0;
`endif

  // Next-state decode plus busy/done status straight from the state.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == FIN);
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          if (empty_req) state_d = AFTER_REGS;
          else           state_d = READ;
        end
      end
      READ: state_d = SEND;
      SEND: begin
        if (hs) begin
          if (dump_is_chk)  state_d = FIN;
          else if (at_last) state_d = AFTER_REGS;
          else              state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      CHK:     state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight beat immediately.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Index walk, read-port address and the registered output beat.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cur_q      <= '0;
      last_q     <= '0;
      rf_addr    <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            cur_q  <= start_idx;
            last_q <= end_idx;
            // rf_addr only moves when a READ follows, so an empty range leaves it alone.
            if (!empty_req) rf_addr <= start_idx;
          end
        end
        READ: begin
          // rf_data is captured here only; later register writes cannot disturb the beat.
          dump_valid <= 1'b1;
          dump_data  <= rf_data;
          dump_idx   <= cur_q;
`ifdef REG_DUMP_CHECKSUM_EN
          dump_last  <= 1'b0;
`else
          dump_last  <= at_last;
`endif
        end
        SEND: begin
          if (hs) begin
            dump_valid <= 1'b0;
            // Termination is at cur==last, so the increment never has to wrap.
            if (!at_last) begin
              cur_q   <= cur_q + IDX_ONE;
              rf_addr <= cur_q + IDX_ONE;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CHK: begin
          dump_valid <= 1'b1;
          dump_data  <= chk_q;
          dump_idx   <= '0;
          dump_last  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Running XOR of accepted register beats, and the flag marking the checksum beat.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      chk_q    <= '0;
      is_chk_q <= 1'b0;
    end else begin
      if (state_q == IDLE && dump_start)
        chk_q <= '0;
      else if (state_q == SEND && hs && !is_chk_q)
        chk_q <= chk_q ^ dump_data;

      if (state_q == CHK)
        is_chk_q <= 1'b1;
      else if (state_q == READ || state_q == FIN)
        is_chk_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench for reg_dump_reader with a register-file model on the read port.
// Latency: expects the first beat 2 cycles after dump_start and done exactly once per dump.
// Backpressure: dump_ready is driven always-high, random, or scripted; held beats must stay stable.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        is_chk;
  } beat_t;

  logic        cpu_clk    = 1'b0;
  logic        cpu_rst    = 1'b1;
  logic        dump_start = 1'b0;
  logic [4:0]  start_idx  = '0;
  logic [4:0]  end_idx    = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_last;
  logic        dump_is_chk;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  beat_t       exp_q [$];
  int          checks     = 0;
  int          failures   = 0;
  int          rdy_mode   = 0;
  logic        rdy_manual = 1'b1;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat;

  reg_dump_reader dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .dump_start  (dump_start),
    .start_idx   (start_idx),
    .end_idx     (end_idx),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_idx    (dump_idx),
    .dump_last   (dump_last),
    .dump_is_chk (dump_is_chk),
    .busy        (busy),
    .done        (done)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Combinational register-file read port.
  assign rf_data = rf[rf_addr];

  // Consumer ready: 0 = always ready, 1 = random, 2 = scripted via rdy_manual.
  always @(posedge cpu_clk) begin
    #2;
    if (rdy_mode == 0)      dump_ready = 1'b1;
    else if (rdy_mode == 1) dump_ready = 1'($urandom_range(0, 1));
    else                    dump_ready = rdy_manual;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: the beats a dump of s..e must produce, from the current register contents.
  task automatic push_expected(input logic [4:0] s, input logic [4:0] e);
    beat_t       b;
    logic [31:0] x = '0;
    for (int i = int'(s); i <= int'(e); i++) begin
      b.data   = rf[i];
      b.idx    = 5'(i);
      b.last   = CHK_EN ? 1'b0 : (i == int'(e));
      b.is_chk = 1'b0;
      exp_q.push_back(b);
      x = x ^ rf[i];
    end
    if (CHK_EN) begin
      b.data   = x;
      b.idx    = '0;
      b.last   = 1'b1;
      b.is_chk = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Monitor: compares each accepted beat with the scoreboard and checks stalled beats stay put.
  always @(negedge cpu_clk) begin
    beat_t got;
    beat_t e;
    if (cpu_rst) begin
      prev_stall = 1'b0;
    end else begin
      got = {dump_data, dump_idx, dump_last, dump_is_chk};
      if (prev_stall) check("hold_stable", 64'({dump_valid, got}), 64'({1'b1, prev_beat}));
      prev_stall = 1'b0;
      if (dump_valid) begin
        if (dump_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", got);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(got), 64'(e));
          end
        end else begin
          prev_stall = 1'b1;
          prev_beat  = got;
        end
      end
    end
  end

  // Issue one dump and follow it to completion; caller is at posedge+1.
  task automatic run_dump(input logic [4:0] s, input logic [4:0] e);
    int nd = 0;
    push_expected(s, e);
    dump_start = 1'b1;
    start_idx  = s;
    end_idx    = e;
    @(posedge cpu_clk); #1;
    dump_start = 1'b0;
    start_idx  = 5'($urandom);
    end_idx    = 5'($urandom);
    if (done) nd++;
    if (s <= e) begin
      check("lat_busy", 64'(busy), 64'(1));
      check("lat_no_valid_yet", 64'(dump_valid), 64'(0));
    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
      check("empty_chk_busy", 64'(busy), 64'(1));
`else
      check("empty_done_next", 64'(done), 64'(1));
`endif
    end
    @(posedge cpu_clk); #1;
    if (done) nd++;
    if (s <= e || CHK_EN) check("first_valid_2cyc", 64'(dump_valid), 64'(1));
    for (int c = 0; c < 400 && busy; c++) begin
      @(posedge cpu_clk); #1;
      if (done) nd++;
    end
    check("finish_in_budget", 64'(busy), 64'(0));
    check("done_pulses", 64'(nd), 64'(1));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] s;
    logic [4:0] e;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;

    // Reset state.
    repeat (2) @(posedge cpu_clk); #1;
    check("rst_outputs", 64'({rf_addr, dump_valid, dump_data, dump_idx, dump_last, dump_is_chk, busy, done}), 64'(0));
    @(negedge cpu_clk); cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;
    check("idle_after_reset", 64'({busy, dump_valid, done}), 64'(0));

    // Two-register dump, always ready.
    rf[1] = 32'hDEADBEEF;
    rf[2] = 32'h12345678;
    run_dump(5'd1, 5'd2);

    // First beat stalled for 5 cycles; register rewritten while held.
    rdy_mode   = 2;
    rdy_manual = 1'b0;
    fork
      run_dump(5'd1, 5'd2);
      begin
        for (int k = 0; k < 20 && !dump_valid; k++) begin @(posedge cpu_clk); #1; end
        rf[dump_idx] = $urandom;
        repeat (5) @(posedge cpu_clk);
        #1 rdy_manual = 1'b1;
      end
    join
    rdy_mode = 0;

    // Full range, single-register at the top index, empty range.
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    run_dump(5'd0, 5'd31);
    run_dump(5'd31, 5'd31);
    run_dump(5'd5, 5'd3);

    // dump_start mid-dump must be ignored.
    rdy_mode = 1;
    fork
      run_dump(5'd4, 5'd12);
      begin
        repeat (6) @(posedge cpu_clk);
        #1;
        dump_start = 1'b1;
        start_idx  = 5'd0;
        end_idx    = 5'd31;
        @(posedge cpu_clk); #1;
        dump_start = 1'b0;
      end
    join
    repeat (3) @(posedge cpu_clk);
    #1;
    check("ignored_start_no_restart", 64'(busy), 64'(0));

    // Random ranges and contents with random backpressure.
    for (int n = 0; n < 8; n++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rf[0] = '0;
      s = 5'($urandom);
      e = 5'($urandom);
      if (n % 3 == 0 && s > e) begin
        logic [4:0] t = s;
        s = e;
        e = t;
      end
      run_dump(s, e);
    end

    // Asynchronous reset while a beat is held.
    rdy_mode   = 2;
    rdy_manual = 1'b0;
    dump_start = 1'b1;
    start_idx  = 5'd3;
    end_idx    = 5'd10;
    @(posedge cpu_clk); #1;
    dump_start = 1'b0;
    for (int k = 0; k < 10 && !dump_valid; k++) begin @(posedge cpu_clk); #1; end
    check("pre_reset_valid", 64'(dump_valid), 64'(1));
    @(negedge cpu_clk);
    #2 cpu_rst = 1'b1;
    #1;
    check("async_rst_outputs", 64'({rf_addr, dump_valid, dump_data, dump_idx, dump_last, dump_is_chk, busy, done}), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge cpu_clk);
    cpu_rst  = 1'b0;
    rdy_mode = 0;
    @(posedge cpu_clk); #1;
    run_dump(5'd0, 5'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
